stream_checker: RTL and testbench
=================================

// Module: stream_checker
// PURPOSE
//  Synthesizable self-checking stream monitor for CHIP-style start/ready datapaths.
//  After arm, compares each DUT output word (sampled while dut_ready=1) with an
//  expected word read from a synchronous ROM. Generalises the fixed 3000-sample
//  checker with parametrised width, length, compare mask, stall tolerance, timeout.
//  Reports error count, first mismatch, done/pass. Sits beside the DUT in on-chip BIST.
// PARAMETERS
//  DATA_W   16       DUT output / expected word width
//  LEN      3000     samples per run (1..2**IDX_W)
//  IDX_W    12       width of index, exp_addr, err_count, first_err_idx
//  TIMEOUT  1024     max consecutive cycles in RUN with dut_ready=0 (>=1)
//  TMR_W    11       timer width, must hold TIMEOUT
//  CMP_MASK {DATA_W{1'b1}}  bit mask; only set bits are compared
// PORTS
//  clock          in   1       single clock, all state on rising edge
//  reset          in   1       synchronous, active-high
//  arm            in   1       start a run (sampled in IDLE or DONE only)
//  dut_ready      in   1       DUT output valid this cycle
//  dut_out        in   DATA_W  DUT output word
//  exp_addr       out  IDX_W   expected-ROM address (ROM read latency = 1 cycle)
//  exp_data       in   DATA_W  ROM data for address presented the previous cycle
//  busy           out  1       high in RUN
//  done           out  1       high in DONE
//  pass           out  1       done & err_count==0 & !timeout
//  timeout        out  1       run ended by TIMEOUT expiry
//  err_count      out  IDX_W   mismatches this run, saturates at all-ones
//  first_err_idx  out  IDX_W   index of first mismatch
//  first_err_got  out  DATA_W  dut_out at first mismatch
//  first_err_exp  out  DATA_W  exp_data at first mismatch
// BEHAVIOUR
//  Reset: state=IDLE; idx, timer, err_count, first_err_* = 0; busy/done/pass/timeout = 0.
//  States: IDLE -> RUN on arm. RUN -> DONE on fire with idx==LEN-1, or timer==TIMEOUT.
//   DONE -> RUN on arm (new run). arm in RUN ignored. No other transitions.
//  Entering RUN: idx=0, timer=0, err_count=0, first_err_*=0, timeout=0, have_err=0.
//  fire = (state==RUN) & dut_ready. One sample compared per fire; no fixed latency from
//   arm; first fire may be any cycle after arm (leading idle tolerated).
//  mismatch = fire & |((dut_out ^ exp_data) & CMP_MASK).
//  On fire: idx<=idx+1 (except last), timer<=0; on mismatch err_count+1 (sat), and if
//   !have_err capture first_err_idx=idx, _got=dut_out, _exp=exp_data, set have_err.
//  RUN & !dut_ready: stall; idx, exp_addr hold; timer+1. timer==TIMEOUT -> DONE, timeout=1.
//  exp_addr combinational = fire ? idx+1 : idx (IDLE/DONE: idx). Guarantees exp_data is
//   ROM[idx] in every RUN cycle; on last fire exp_addr=LEN (don't-care read).
//  Status outputs registered; done/pass/timeout/err/first_err_* hold in DONE until arm or reset.
//  Reset mid-run overrides everything: back to IDLE with reset values next cycle.
//  arm & reset same cycle: reset wins.
// TESTING
//  1 arm, dut_out==ROM for 3000 samples, dut_ready=1 continuously -> done 1 cycle after
//    3000th fire, pass=1, err_count=0, busy=0.
//  2 corrupt idx 5 (0x1234 vs 0x1235) and idx 2999 -> err_count=2, first_err_idx=5,
//    first_err_got=0x1235, first_err_exp=0x1234, pass=0.
//  3 dut_ready low 10 cycles at idx 100 -> exp_addr held 100, no errors, pass=1.
//  4 arm, dut_ready never high, TIMEOUT=1024 -> done & timeout at cycle 1025 after arm, pass=0.
//  5 reset at idx 1500 -> all outputs 0, IDLE; re-arm restarts at idx 0, clean pass.
//  6 CMP_MASK=16'h00FF, mismatch only in bits[15:8] -> err_count=0; arm during RUN
//    ignored; arm in DONE clears counters and reruns.

Source files
------------

// File: rtl/stream_checker.sv
// Stream checker: compares DUT output words against an expected-word ROM after arm,
// reporting mismatch count, first mismatch, timeout and pass/done status.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for arm after reset
// S_RUN  | comparing samples on each dut_ready, stall timer running
// S_DONE | run finished (all samples or timeout), status held until arm
module stream_checker #(
    parameter int                DATA_W   = 16,
    parameter int                LEN      = 3000,
    parameter int                IDX_W    = 12,
    parameter int                TIMEOUT  = 1024,
    parameter int                TMR_W    = 11,
    parameter logic [DATA_W-1:0] CMP_MASK = {DATA_W{1'b1}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arm,
    input  logic              dut_ready,
    input  logic [DATA_W-1:0] dut_out,
    output logic [IDX_W-1:0]  exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [IDX_W-1:0]  err_count,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_got,
    output logic [DATA_W-1:0] first_err_exp
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] ERR_MAX  = '1;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx;
    logic [TMR_W-1:0]  tmr;
    logic              have_err;
    logic              timeout_q;
    logic              fire;
    logic              start;
    logic              expire;
    logic              mismatch;

    always_comb begin
        state_nx = state;
        fire     = 1'b0;
        start    = 1'b0;
        expire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    state_nx = S_RUN;
                    start    = 1'b1;
                end
            end
            S_RUN: begin
                fire   = dut_ready;
                // tmr counts down from TIMEOUT; a stall with tmr at zero is the
                // (TIMEOUT+1)-th consecutive idle cycle
                expire = !dut_ready && (tmr == '0);
                if ((fire && (idx == LAST_IDX)) || expire) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (arm) begin
                    state_nx = S_RUN;
                    start    = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign mismatch = fire && (|((dut_out ^ exp_data) & CMP_MASK));

    // On the arm cycle the ROM must be pointed at word 0 so the first RUN cycle
    // already sees ROM[0], even when re-arming from DONE with idx at LEN-1.
    always_comb begin
        exp_addr = idx;
        if (fire) begin
            exp_addr = idx + 1'b1;
        end else if (start) begin
            exp_addr = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            idx           <= '0;
            tmr           <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
            have_err      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                idx           <= '0;
                tmr           <= TMR_LOAD;
                err_count     <= '0;
                first_err_idx <= '0;
                first_err_got <= '0;
                first_err_exp <= '0;
                have_err      <= 1'b0;
                timeout_q     <= 1'b0;
            end else if (state == S_RUN) begin
                if (fire) begin
                    if (idx != LAST_IDX) begin
                        idx <= idx + 1'b1;
                    end
                    tmr <= TMR_LOAD;
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!have_err) begin
                            have_err      <= 1'b1;
                            first_err_idx <= idx;
                            first_err_got <= dut_out;
                            first_err_exp <= exp_data;
                        end
                    end
                end else if (expire) begin
                    timeout_q <= 1'b1;
                end else begin
                    tmr <= tmr - 1'b1;
                end
            end
        end
    end

    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);
    assign timeout = timeout_q;
    assign pass    = done && (err_count == '0) && !timeout_q;

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: full-mask and low-byte-mask instances fed from
// one behavioural ROM, with hand-derived expectations checked by immediate assertions.
module tb_stream_checker;

    localparam int DATA_W  = 16;
    localparam int LEN     = 3000;
    localparam int IDX_W   = 12;
    localparam int TIMEOUT = 1024;
    localparam int TMR_W   = 11;

    logic              clock;
    logic              reset;
    logic              arm;
    logic              dut_ready;
    logic [DATA_W-1:0] dut_out;

    logic [IDX_W-1:0]  exp_addr,      exp_addr_m;
    logic [DATA_W-1:0] exp_data,      exp_data_m;
    logic              busy,          busy_m;
    logic              done,          done_m;
    logic              pass,          pass_m;
    logic              timeout,       timeout_m;
    logic [IDX_W-1:0]  err_count,     err_count_m;
    logic [IDX_W-1:0]  first_err_idx, first_err_idx_m;
    logic [DATA_W-1:0] first_err_got, first_err_got_m;
    logic [DATA_W-1:0] first_err_exp, first_err_exp_m;

    logic [DATA_W-1:0] rom  [0:4095];
    logic [DATA_W-1:0] flip [0:4095];

    int checks;
    int failures;

    stream_checker #(
        .DATA_W(DATA_W), .LEN(LEN), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)
    ) u_dut (
        .clock(clock), .reset(reset), .arm(arm), .dut_ready(dut_ready), .dut_out(dut_out),
        .exp_addr(exp_addr), .exp_data(exp_data), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_got(first_err_got), .first_err_exp(first_err_exp)
    );

    stream_checker #(
        .DATA_W(DATA_W), .LEN(LEN), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W),
        .CMP_MASK(16'h00FF)
    ) u_mask (
        .clock(clock), .reset(reset), .arm(arm), .dut_ready(dut_ready), .dut_out(dut_out),
        .exp_addr(exp_addr_m), .exp_data(exp_data_m), .busy(busy_m), .done(done_m),
        .pass(pass_m), .timeout(timeout_m), .err_count(err_count_m),
        .first_err_idx(first_err_idx_m), .first_err_got(first_err_got_m),
        .first_err_exp(first_err_exp_m)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // synchronous ROMs, one-cycle read latency
    always @(posedge clock) begin
        exp_data   <= rom[exp_addr];
        exp_data_m <= rom[exp_addr_m];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, expv);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_flips;
        for (int i = 0; i < 4096; i++) flip[i] = '0;
    endtask

    task automatic arm_run(input string tag);
        arm       = 1'b1;
        dut_ready = 1'b0;
        tick();
        arm = 1'b0;
        check({tag, "_busy"},    32'(busy),      32'd1);
        check({tag, "_done"},    32'(done),      32'd0);
        check({tag, "_errcnt"},  32'(err_count), 32'd0);
        check({tag, "_timeout"}, 32'(timeout),   32'd0);
    endtask

    // Drive samples 0..stop_at-1, optional stall before sample stall_at,
    // optional arm pulse together with sample arm_at.
    task automatic stream(input int stall_at, input int stall_len, input int arm_at,
                          input int stop_at);
        for (int k = 0; k < stop_at; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    dut_ready = 1'b0;
                    arm       = 1'b0;
                    #1;
                    check("stall_exp_addr", 32'(exp_addr), 32'(k));
                    tick();
                end
            end
            dut_ready = 1'b1;
            dut_out   = rom[k] ^ flip[k];
            arm       = (k == arm_at);
            if (k == LEN - 1) check("done_before_last", 32'(done), 32'd0);
            tick();
        end
        dut_ready = 1'b0;
        arm       = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        arm       = 1'b0;
        dut_ready = 1'b0;
        dut_out   = '0;
        for (int i = 0; i < 4096; i++) rom[i] = 16'(i * 40503 + 7);
        rom[5] = 16'h1234;
        clear_flips();

        tick(); tick(); tick();
        check("rst_busy",    32'(busy),          32'd0);
        check("rst_done",    32'(done),          32'd0);
        check("rst_pass",    32'(pass),          32'd0);
        check("rst_timeout", 32'(timeout),       32'd0);
        check("rst_errcnt",  32'(err_count),     32'd0);
        check("rst_fidx",    32'(first_err_idx), 32'd0);
        check("rst_addr",    32'(exp_addr),      32'd0);

        // arm together with reset: reset wins
        arm = 1'b1;
        tick();
        check("arm_rst_busy", 32'(busy), 32'd0);
        arm   = 1'b0;
        reset = 1'b0;
        tick();

        // 1: clean full run
        arm_run("t1");
        stream(-1, 0, -1, LEN);
        check("t1_done",   32'(done),      32'd1);
        check("t1_busy",   32'(busy),      32'd0);
        check("t1_pass",   32'(pass),      32'd1);
        check("t1_errcnt", 32'(err_count), 32'd0);

        // 2: corruptions at idx 5 and last index, re-armed from DONE
        flip[5]    = 16'h0001;
        flip[2999] = 16'h8000;
        arm_run("t2");
        stream(-1, 0, -1, LEN);
        check("t2_done",   32'(done),          32'd1);
        check("t2_errcnt", 32'(err_count),     32'd2);
        check("t2_fidx",   32'(first_err_idx), 32'd5);
        check("t2_fgot",   32'(first_err_got), 32'h1235);
        check("t2_fexp",   32'(first_err_exp), 32'h1234);
        check("t2_pass",   32'(pass),          32'd0);

        // 3: 10-cycle stall at idx 100
        clear_flips();
        arm_run("t3");
        stream(100, 10, -1, LEN);
        check("t3_errcnt", 32'(err_count), 32'd0);
        check("t3_pass",   32'(pass),      32'd1);

        // 4: dut_ready never rises -> timeout
        arm_run("t4");
        for (int i = 0; i < TIMEOUT; i++) tick();
        check("t4_done_early", 32'(done), 32'd0);
        tick();
        check("t4_done",    32'(done),    32'd1);
        check("t4_timeout", 32'(timeout), 32'd1);
        check("t4_pass",    32'(pass),    32'd0);
        check("t4_busy",    32'(busy),    32'd0);

        // 5: reset mid-run at idx 1500, then clean rerun
        flip[700] = 16'h8000;
        arm_run("t5");
        stream(-1, 0, -1, 1500);
        check("t5_errcnt_pre", 32'(err_count), 32'd1);
        check("t5_busy_pre",   32'(busy),      32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_busy",    32'(busy),          32'd0);
        check("t5_done",    32'(done),          32'd0);
        check("t5_pass",    32'(pass),          32'd0);
        check("t5_timeout", 32'(timeout),       32'd0);
        check("t5_errcnt",  32'(err_count),     32'd0);
        check("t5_fidx",    32'(first_err_idx), 32'd0);
        check("t5_fgot",    32'(first_err_got), 32'd0);
        check("t5_fexp",    32'(first_err_exp), 32'd0);
        check("t5_addr",    32'(exp_addr),      32'd0);
        clear_flips();
        arm_run("t5r");
        stream(-1, 0, -1, LEN);
        check("t5r_pass", 32'(pass), 32'd1);

        // 6: masked instance, arm during RUN ignored, arm in DONE reruns
        flip[10] = 16'h0100;
        flip[20] = 16'hFF00;
        flip[30] = 16'h0001;
        arm_run("t6");
        stream(-1, 0, 50, LEN);
        check("t6_done",     32'(done),            32'd1);
        check("t6_errcnt",   32'(err_count),       32'd3);
        check("t6_fidx",     32'(first_err_idx),   32'd10);
        check("t6_fgot",     32'(first_err_got),   32'(rom[10] ^ 16'h0100));
        check("t6_fexp",     32'(first_err_exp),   32'(rom[10]));
        check("t6m_done",    32'(done_m),          32'd1);
        check("t6m_errcnt",  32'(err_count_m),     32'd1);
        check("t6m_fidx",    32'(first_err_idx_m), 32'd30);
        check("t6m_pass",    32'(pass_m),          32'd0);
        flip[30] = '0;
        arm_run("t6r");
        check("t6r_fidx", 32'(first_err_idx), 32'd0);
        stream(-1, 0, -1, LEN);
        check("t6r_errcnt",  32'(err_count),   32'd2);
        check("t6rm_errcnt", 32'(err_count_m), 32'd0);
        check("t6rm_pass",   32'(pass_m),      32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
